// File: rtl/mem_arbiter.sv
// Multi-cycle arbiter for CPU fetch/data across two external SRAMs and the UART.
// Fetch runs on SRAM2 whenever no data op owns it; data ops stall the pipeline via ram_pause.
module mem_arbiter #(
  parameter int unsigned       DATA_W        = 16,
  parameter int unsigned       ADDR_W        = 18,
  parameter int unsigned       PC_W          = 16,
  parameter logic [ADDR_W-1:0] SPLIT_ADDR    = 18'h8000,
  parameter logic [ADDR_W-1:0] COM_DATA_ADDR = 18'hBF00,
  parameter logic [ADDR_W-1:0] COM_STAT_ADDR = 18'hBF01,
  parameter int unsigned       RD_CYCLES     = 1,
  parameter int unsigned       WR_PULSE      = 1,
  parameter int unsigned       RDN_PULSE     = 2
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] sram1_data,
  output logic [ADDR_W-1:0] sram1_addr,
  output logic              sram1_en,
  output logic              sram1_oe,
  output logic              sram1_we,
  inout  wire  [DATA_W-1:0] sram2_data,
  output logic [ADDR_W-1:0] sram2_addr,
  output logic              sram2_en,
  output logic              sram2_oe,
  output logic              sram2_we,
  input  logic              en,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              tsre,
  input  logic              tbre,
  input  logic              data_ready,
  output logic              rdn,
  output logic              wrn,
  output logic              ram_pause
);

  // state      | meaning
  // IDLE       | waiting for en; target decoded and latched on acceptance
  // ACCESS     | SRAM address/control phase (read wait or write setup)
  // STROBE     | SRAM WE low for WR_PULSE cycles
  // COM_WAIT   | UART not ready yet; stalls with no timeout
  // COM_STROBE | rdn/wrn low for the programmed pulse width
  // DONE       | one-cycle completion, ram_pause released

  localparam int unsigned MAX_RW = (RD_CYCLES > WR_PULSE) ? RD_CYCLES : WR_PULSE;
  localparam int unsigned MAX_P  = (MAX_RW > RDN_PULSE) ? MAX_RW : RDN_PULSE;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {IDLE, ACCESS, STROBE, COM_WAIT, COM_STROBE, DONE} state_t;
  typedef enum logic [1:0] {T_SRAM1, T_SRAM2, T_STAT, T_DATA} tgt_t;

  state_t             state_q, state_d;
  tgt_t               tgt_q, tgt_d;
  logic               wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_o_q, data_o_d;

  logic               last_rd, last_wr, last_rdn;
  logic               on_sram2;
  logic               sram1_drv, sram2_drv;
  logic [DATA_W-1:0]  sram1_wdata;

  assign last_rd  = (cnt_q == CNT_W'(RD_CYCLES - 1));
  assign last_wr  = (cnt_q == CNT_W'(WR_PULSE - 1));
  assign last_rdn = (cnt_q == CNT_W'(RDN_PULSE - 1));

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    wr_d     = wr_q;
    data_o_d = data_o_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          wr_d = op;
          if (addr == COM_STAT_ADDR) begin
            tgt_d   = T_STAT;
            state_d = DONE;
            if (!op) data_o_d = DATA_W'({data_ready, tsre & tbre});
          end else if (addr == COM_DATA_ADDR) begin
            tgt_d   = T_DATA;
            state_d = COM_WAIT;
          end else begin
            tgt_d   = (addr < SPLIT_ADDR) ? T_SRAM2 : T_SRAM1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = STROBE;
        end else if (last_rd) begin
          state_d  = DONE;
          data_o_d = (tgt_q == T_SRAM2) ? sram2_data : sram1_data;
        end
      end
      STROBE:   if (last_wr) state_d = DONE;
      COM_WAIT: if (wr_q ? (tbre & tsre) : data_ready) state_d = COM_STROBE;
      COM_STROBE: begin
        if (wr_q && last_wr) begin
          state_d = DONE;
        end else if (!wr_q && last_rdn) begin
          state_d  = DONE;
          data_o_d = DATA_W'(sram1_data[7:0]);
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Counter restarts on every state entry and saturates during long UART waits.
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == '1)   cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_q    <= T_SRAM1;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      data_o_q <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      data_o_q <= data_o_d;
    end
  end

  assign on_sram2 = (tgt_q == T_SRAM2) && (state_q != IDLE);

  always_comb begin
    sram1_en    = 1'b1;
    sram1_oe    = 1'b1;
    sram1_we    = 1'b1;
    sram1_drv   = 1'b0;
    sram1_wdata = data_i;
    sram2_en    = 1'b1;
    sram2_oe    = 1'b1;
    sram2_we    = 1'b1;
    sram2_drv   = 1'b0;
    sram2_addr  = {{(ADDR_W-PC_W){1'b0}}, pc};
    inst_valid  = 1'b0;
    rdn         = 1'b1;
    wrn         = 1'b1;

    if (tgt_q == T_SRAM1 && state_q inside {ACCESS, STROBE, DONE}) begin
      if (wr_q) begin
        sram1_en  = 1'b0;
        sram1_drv = 1'b1;
        sram1_we  = (state_q != STROBE);
      end else if (state_q == ACCESS) begin
        sram1_en = 1'b0;
        sram1_oe = 1'b0;
      end
    end

    if (tgt_q == T_DATA) begin
      if (state_q == COM_STROBE) begin
        rdn = wr_q;
        wrn = !wr_q;
      end
      if (wr_q && state_q inside {COM_STROBE, DONE}) begin
        sram1_drv   = 1'b1;
        sram1_wdata = DATA_W'(data_i[7:0]);
      end
    end

    if (on_sram2) begin
      sram2_addr = addr;
      if (wr_q) begin
        sram2_en  = 1'b0;
        sram2_drv = 1'b1;
        sram2_we  = (state_q != STROBE);
      end else if (state_q == ACCESS) begin
        sram2_en = 1'b0;
        sram2_oe = 1'b0;
      end
    end else if (!rst) begin
      sram2_en   = 1'b0;
      sram2_oe   = 1'b0;
      inst_valid = 1'b1;
    end
  end

  assign sram1_addr = addr;
  assign sram1_data = sram1_drv ? sram1_wdata : {DATA_W{1'bz}};
  assign sram2_data = sram2_drv ? data_i : {DATA_W{1'bz}};
  assign inst       = sram2_data;
  assign data_o     = data_o_q;
  assign ram_pause  = en && (state_q != DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM/UART device models plus a transaction-level reference
// (cycle counts and data predicted from the access rules, memory contents in an associative array).
module tb_mem_arbiter;
  localparam int RD = 1, WRP = 1, RDNP = 2;
  localparam logic [17:0] SPLIT = 18'h8000, CDATA = 18'hBF00, CSTAT = 18'hBF01;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, op = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] data_i = '0;
  logic [15:0] pc = '0;
  logic        tsre = 1'b0;
  logic        tbre, data_ready;
  wire  [15:0] sram1_data, sram2_data;
  logic [17:0] sram1_addr, sram2_addr;
  logic        sram1_en, sram1_oe, sram1_we, sram2_en, sram2_oe, sram2_we;
  logic [15:0] data_o, inst;
  logic        inst_valid, rdn, wrn, ram_pause;

  int errors = 0, checks = 0;
  int wait_cnt = 0, dr_delay = 1000, tx_delay = 1000;
  logic [7:0]  uart_byte = 8'h00;
  logic [15:0] mem1 [0:1023];
  logic [15:0] mem2 [0:1023];
  logic        tb1_drv, tb2_drv;
  logic [15:0] tb1_val, tb2_val;

  always #10 clk_50MHz = ~clk_50MHz;

  mem_arbiter dut (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .sram1_data(sram1_data), .sram1_addr(sram1_addr),
    .sram1_en(sram1_en), .sram1_oe(sram1_oe), .sram1_we(sram1_we),
    .sram2_data(sram2_data), .sram2_addr(sram2_addr),
    .sram2_en(sram2_en), .sram2_oe(sram2_oe), .sram2_we(sram2_we),
    .en(en), .op(op), .addr(addr), .data_i(data_i), .data_o(data_o),
    .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .tsre(tsre), .tbre(tbre), .data_ready(data_ready),
    .rdn(rdn), .wrn(wrn), .ram_pause(ram_pause)
  );

  // UART readiness counts cycles since en rose
  always @(posedge clk_50MHz) wait_cnt <= en ? wait_cnt + 1 : 0;
  assign tbre       = (wait_cnt >= tx_delay);
  assign data_ready = (wait_cnt >= dr_delay);

  assign tb1_drv = (!sram1_oe && !sram1_en) || !rdn;
  assign tb1_val = !rdn ? {8'hC3, uart_byte} : mem1[sram1_addr[9:0]];
  assign tb2_drv = !sram2_oe && !sram2_en;
  assign tb2_val = mem2[sram2_addr[9:0]];
  assign sram1_data = tb1_drv ? tb1_val : 16'hzzzz;
  assign sram2_data = tb2_drv ? tb2_val : 16'hzzzz;

  always @(posedge clk_50MHz) begin
    if (!sram1_en && !sram1_we) mem1[sram1_addr[9:0]] <= sram1_data;
    if (!sram2_en && !sram2_we) mem2[sram2_addr[9:0]] <= sram2_data;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic run_op(input logic op_i, input logic [17:0] a, input logic [15:0] d,
                        output int pause_n, output int we1_n, output int en1_n,
                        output int inval_n, output int a2_bad, output int wrn_n,
                        output int rdn_n, output int conflict_n,
                        output logic [7:0] wbyte, output bit timed_out);
    pause_n = 0; we1_n = 0; en1_n = 0; inval_n = 0; a2_bad = 0;
    wrn_n = 0; rdn_n = 0; conflict_n = 0; wbyte = 8'h00; timed_out = 1'b1;
    en = 1'b1; op = op_i; addr = a; data_i = d;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (!sram1_we) we1_n++;
      if (!sram1_en) en1_n++;
      if (!inst_valid) begin
        inval_n++;
        if (sram2_addr !== a) a2_bad++;
      end
      if (!wrn) begin wrn_n++; wbyte = sram1_data[7:0]; end
      if (!rdn) rdn_n++;
      if ((dut.sram1_drv && !sram1_oe) || (dut.sram2_drv && !sram2_oe)) conflict_n++;
      if (!ram_pause) begin timed_out = 1'b0; break; end
      pause_n++;
      @(posedge clk_50MHz); #1;
    end
    @(posedge clk_50MHz); #1;
    en = 1'b0;
    @(posedge clk_50MHz); #1;
  endtask

  function automatic int uart_pause(input int delay, input int pulse);
    return 1 + ((delay < 1) ? 1 : delay) + pulse;
  endfunction

  task automatic test_reset();
    int p, w, e, iv, ab, wn, rn, cf; logic [7:0] wb; bit to;
    rst = 1'b1; en = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    #1;
    checks++; if ({sram1_en, sram1_oe, sram1_we} !== 3'b111) begin errors++;
      $display("FAIL reset_sram1_ctl: got %b expected 111", {sram1_en, sram1_oe, sram1_we}); end
    checks++; if ({sram2_en, sram2_oe, sram2_we} !== 3'b111) begin errors++;
      $display("FAIL reset_sram2_ctl: got %b expected 111", {sram2_en, sram2_oe, sram2_we}); end
    checks++; if ({rdn, wrn} !== 2'b11) begin errors++;
      $display("FAIL reset_uart_strobes: got %b expected 11", {rdn, wrn}); end
    checks++; if (data_o !== 16'h0000) begin errors++;
      $display("FAIL reset_data_o: got %h expected 0000", data_o); end
    checks++; if (dut.sram1_drv !== 1'b0 || dut.sram2_drv !== 1'b0) begin errors++;
      $display("FAIL reset_bus_release: got %b%b expected 00", dut.sram1_drv, dut.sram2_drv); end
    rst = 1'b0;
    @(posedge clk_50MHz); #1;
    run_op(1'b1, 18'h8123, 16'hBEEF, p, w, e, iv, ab, wn, rn, cf, wb, to);
    run_op(1'b0, 18'h8123, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (data_o !== 16'hBEEF) begin errors++;
      $display("FAIL pre_reset_read: got %h expected beef", data_o); end
    // start a write to 9000 and reset while WE is low
    en = 1'b1; op = 1'b1; addr = 18'h9000; data_i = 16'h7777;
    @(posedge clk_50MHz); @(posedge clk_50MHz); #1;
    checks++; if (sram1_we !== 1'b0) begin errors++;
      $display("FAIL strobe_reached: sram1_we got %b expected 0", sram1_we); end
    rst = 1'b1;
    @(posedge clk_50MHz); #1;
    checks++; if ({sram1_en, sram1_we} !== 2'b11) begin errors++;
      $display("FAIL midop_reset_ctl: got %b expected 11", {sram1_en, sram1_we}); end
    checks++; if (dut.sram1_drv !== 1'b0) begin errors++;
      $display("FAIL midop_reset_bus: drive got %b expected 0", dut.sram1_drv); end
    checks++; if (data_o !== 16'h0000) begin errors++;
      $display("FAIL midop_reset_data_o: got %h expected 0000", data_o); end
    en = 1'b0; rst = 1'b0;
    @(posedge clk_50MHz); #1;
    run_op(1'b0, 18'h8123, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (to || p != 1 + RD) begin errors++;
      $display("FAIL post_reset_idle: pause got %0d expected %0d (timeout=%0d)", p, 1 + RD, to); end
  endtask

  task automatic test_sram1();
    int p, w, e, iv, ab, wn, rn, cf; logic [7:0] wb; bit to;
    run_op(1'b1, 18'h9000, 16'hA5A5, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (to || p != 2 + WRP) begin errors++;
      $display("FAIL sram1_wr_pause: got %0d expected %0d", p, 2 + WRP); end
    checks++; if (w != WRP) begin errors++;
      $display("FAIL sram1_we_width: got %0d expected %0d", w, WRP); end
    checks++; if (iv != 0) begin errors++;
      $display("FAIL sram1_wr_fetch: inst_valid low %0d cycles expected 0", iv); end
    run_op(1'b0, 18'h9000, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (to || p != 1 + RD) begin errors++;
      $display("FAIL sram1_rd_pause: got %0d expected %0d", p, 1 + RD); end
    checks++; if (data_o !== 16'hA5A5) begin errors++;
      $display("FAIL sram1_rd_data: got %h expected a5a5", data_o); end
    checks++; if (iv != 0) begin errors++;
      $display("FAIL sram1_rd_fetch: inst_valid low %0d cycles expected 0", iv); end
  endtask

  task automatic test_sram2_split();
    int p, w, e, iv, ab, wn, rn, cf; logic [7:0] wb; bit to;
    pc = 16'h0042;
    run_op(1'b1, 18'h7FFF, 16'h1234, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (to || iv != 2 + WRP || ab != 0) begin errors++;
      $display("FAIL sram2_wr_owns_bus: invalid %0d (exp %0d) addr_bad %0d", iv, 2 + WRP, ab); end
    checks++; if (w != 0) begin errors++;
      $display("FAIL sram2_wr_not_sram1: sram1_we low %0d expected 0", w); end
    pc = 16'h7FFF;
    run_op(1'b0, 18'h7FFF, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (to || p != 1 + RD || iv != 1 + RD || ab != 0) begin errors++;
      $display("FAIL sram2_rd: pause %0d invalid %0d addr_bad %0d expected %0d/%0d/0", p, iv, ab, 1 + RD, 1 + RD); end
    checks++; if (data_o !== 16'h1234) begin errors++;
      $display("FAIL sram2_rd_data: got %h expected 1234", data_o); end
    checks++; if (inst_valid !== 1'b1 || sram2_addr !== {2'b00, pc} || inst !== 16'h1234) begin errors++;
      $display("FAIL fetch_resume: valid %b addr %h inst %h expected 1 %h 1234", inst_valid, sram2_addr, inst, {2'b00, pc}); end
    run_op(1'b1, SPLIT, 16'h5555, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (iv != 0 || w != WRP) begin errors++;
      $display("FAIL split_goes_sram1: invalid %0d sram1_we %0d expected 0/%0d", iv, w, WRP); end
  endtask

  task automatic test_com_status();
    int p, w, e, iv, ab, wn, rn, cf; logic [7:0] wb; bit to;
    dr_delay = 0; tx_delay = 0; tsre = 1'b0;
    run_op(1'b0, CSTAT, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (to || p != 1) begin errors++;
      $display("FAIL status_pause: got %0d expected 1", p); end
    checks++; if (data_o !== 16'h0002) begin errors++;
      $display("FAIL status_data: got %h expected 0002", data_o); end
    dr_delay = 1000; tx_delay = 1000;
  endtask

  task automatic test_uart_write();
    int p, w, e, iv, ab, wn, rn, cf; logic [7:0] wb; bit to;
    tsre = 1'b1; tx_delay = 5;
    run_op(1'b1, CDATA, 16'h0041, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (to || p != uart_pause(5, WRP)) begin errors++;
      $display("FAIL uart_wr_pause: got %0d expected %0d", p, uart_pause(5, WRP)); end
    checks++; if (wn != WRP || wb !== 8'h41) begin errors++;
      $display("FAIL uart_wr_strobe: wrn low %0d byte %h expected %0d 41", wn, wb, WRP); end
    checks++; if (e != 0 || iv != 0) begin errors++;
      $display("FAIL uart_wr_isolation: sram1_en low %0d invalid %0d expected 0 0", e, iv); end
    tx_delay = 1000;
  endtask

  task automatic test_uart_read();
    int p, w, e, iv, ab, wn, rn, cf; logic [7:0] wb; bit to;
    dr_delay = 3; uart_byte = 8'h5A;
    run_op(1'b0, CDATA, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
    checks++; if (to || p != uart_pause(3, RDNP)) begin errors++;
      $display("FAIL uart_rd_pause: got %0d expected %0d", p, uart_pause(3, RDNP)); end
    checks++; if (rn != RDNP || e != 0) begin errors++;
      $display("FAIL uart_rd_strobe: rdn low %0d sram1_en low %0d expected %0d 0", rn, e, RDNP); end
    checks++; if (data_o !== 16'h005A) begin errors++;
      $display("FAIL uart_rd_data: got %h expected 005a", data_o); end
    dr_delay = 1000;
  endtask

  task automatic test_random();
    int p, w, e, iv, ab, wn, rn, cf; logic [7:0] wb; bit to;
    logic [15:0] ref_mem [logic [17:0]];
    logic [17:0] wq1 [$];
    logic [17:0] wq2 [$];
    logic [15:0] exp_do, d;
    logic [17:0] a;
    int kind, exp_p, exp_iv, dly;
    // anchor the expected data_o with a known status read
    dr_delay = 1; tx_delay = 0; tsre = 1'b1;
    run_op(1'b0, CSTAT, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
    exp_do = 16'h0001;
    checks++; if (data_o !== exp_do) begin errors++;
      $display("FAIL rand_anchor: got %h expected %h", data_o, exp_do); end
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 6);
      if (kind == 1 && wq1.size() == 0) kind = 0;
      if (kind == 3 && wq2.size() == 0) kind = 2;
      pc = 16'($urandom);
      d = 16'($urandom);
      exp_iv = 0;
      case (kind)
        0, 2: begin
          a = (kind == 0) ? SPLIT + 18'($urandom_range(0, 1023)) : 18'h7C00 + 18'($urandom_range(0, 1023));
          ref_mem[a] = d;
          if (kind == 0) wq1.push_back(a); else wq2.push_back(a);
          exp_p = 2 + WRP;
          if (kind == 2) exp_iv = exp_p;
          run_op(1'b1, a, d, p, w, e, iv, ab, wn, rn, cf, wb, to);
        end
        1, 3: begin
          a = (kind == 1) ? wq1[$urandom_range(0, wq1.size() - 1)] : wq2[$urandom_range(0, wq2.size() - 1)];
          exp_do = ref_mem[a];
          exp_p = 1 + RD;
          if (kind == 3) exp_iv = exp_p;
          run_op(1'b0, a, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
        end
        4: begin
          dr_delay = $urandom_range(0, 1); tx_delay = $urandom_range(0, 1); tsre = 1'($urandom);
          exp_do = {14'd0, dr_delay == 0, tsre && (tx_delay == 0)};
          exp_p = 1;
          run_op(1'b0, CSTAT, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
        end
        5: begin
          dly = $urandom_range(0, 4); tx_delay = dly; tsre = 1'b1;
          exp_p = uart_pause(dly, WRP);
          run_op(1'b1, CDATA, d, p, w, e, iv, ab, wn, rn, cf, wb, to);
          checks++; if (wb !== d[7:0] || wn != WRP) begin errors++;
            $display("FAIL rand_uart_wr[%0d]: byte %h wrn %0d expected %h %0d", n, wb, wn, d[7:0], WRP); end
        end
        default: begin
          dly = $urandom_range(0, 4); dr_delay = dly; uart_byte = 8'($urandom);
          exp_do = {8'h00, uart_byte};
          exp_p = uart_pause(dly, RDNP);
          run_op(1'b0, CDATA, 16'h0000, p, w, e, iv, ab, wn, rn, cf, wb, to);
        end
      endcase
      checks++; if (to || p != exp_p) begin errors++;
        $display("FAIL rand_pause[%0d] kind %0d: got %0d expected %0d timeout %0d", n, kind, p, exp_p, to); end
      checks++; if (data_o !== exp_do) begin errors++;
        $display("FAIL rand_data_o[%0d] kind %0d: got %h expected %h", n, kind, data_o, exp_do); end
      checks++; if (iv != exp_iv || ab != 0) begin errors++;
        $display("FAIL rand_fetch[%0d] kind %0d: invalid %0d addr_bad %0d expected %0d 0", n, kind, iv, ab, exp_iv); end
      checks++; if (cf != 0) begin errors++;
        $display("FAIL rand_bus_conflict[%0d]: %0d cycles driving with OE low", n, cf); end
    end
    dr_delay = 1000; tx_delay = 1000;
  endtask

  initial begin
    test_reset();
    test_sram1();
    test_sram2_split();
    test_com_status();
    test_uart_write();
    test_uart_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
